// File: rtl/v_hier_pkg.sv
// v_hier_pkg: shared constants and types
// for the filtered lane array and its change log.
package v_hier_pkg;

    localparam int V_HIER_MODE_PASS = 0;
    localparam int V_HIER_MODE_FILT = 1;

    // Widest lane index needed for up to 64 lanes.
    localparam int V_HIER_IDXW_MAX  = 6;

    typedef struct packed {
        logic [V_HIER_IDXW_MAX-1:0] idx;
        logic                       val;
    } v_hier_evt_t;

    // Index width for n lanes, never below one bit.
    function automatic int v_hier_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/v_hier_lane.sv
// v_hier_lane: one input sampler with a glitch
// filter that flips q after D differing samples.
module v_hier_lane
    import v_hier_pkg::*;
#(
    parameter int D = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_a,
    output logic o_q,
    output logic o_flip
);

    localparam int CW = $clog2(D + 1);

    logic          r_s;
    logic          r_q;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = (r_s != r_q);
    assign w_done = (r_cnt == CW'(D - 1));
    assign o_flip = i_en && w_diff && w_done;
    assign o_q    = r_q;

    // Sample every edge; count differing samples only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s   <= 1'b0;
            r_q   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s <= i_a;
            if (i_en) begin
                if (w_diff) begin
                    if (w_done) begin
                        r_q   <= r_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/v_hier_sub_array.sv
// v_hier_sub_array: array of filtered lanes plus a
// round-robin change-event queue drained over valid/ready.
module v_hier_sub_array
    import v_hier_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 2,
    parameter  int MODE     = 0,
    localparam int IDXW     = v_hier_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] avec,
    output logic [CHANNELS-1:0] qvec,
    output logic                chg_valid,
    input  logic                chg_ready,
    output logic [IDXW-1:0]     chg_idx,
    output logic                chg_val
);

    // Pass-through mode is simply a one-sample filter.
    localparam int D = (MODE == V_HIER_MODE_FILT) ? DEPTH : 1;

    logic [CHANNELS-1:0] w_q;
    logic [CHANNELS-1:0] w_flip;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] r_pend;
    logic [IDXW-1:0]     r_ptr;
    logic [IDXW-1:0]     r_idx;
    logic                r_val;
    logic                r_valid;
    logic                w_found;
    logic                w_take;
    logic [IDXW-1:0]     w_ptr_nxt;
    v_hier_evt_t         w_pick;

    for (genvar g = 0; g < CHANNELS; g++) begin : genloop
        v_hier_lane #(
            .D(D)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en),
            .i_a    (avec[g]),
            .o_q    (w_q[g]),
            .o_flip (w_flip[g])
        );
    end

    // Pick first pending lane at or above ptr, else wrap to the lowest.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && r_pend[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_pick.idx = V_HIER_IDXW_MAX'(i);
                w_pick.val = w_q[i];
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && r_pend[i]) begin
                w_found    = 1'b1;
                w_pick.idx = V_HIER_IDXW_MAX'(i);
                w_pick.val = w_q[i];
            end
        end
    end

    assign w_take = w_found && (!r_valid || chg_ready);

    assign w_ptr_nxt =
        (w_pick.idx == V_HIER_IDXW_MAX'(CHANNELS - 1)) ? '0 :
        IDXW'(w_pick.idx + V_HIER_IDXW_MAX'(1));

    // One-hot clear of the lane moving into the event buffer.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_clr[i] = w_take && (w_pick.idx == V_HIER_IDXW_MAX'(i));
        end
    end

    // Pending flags (a new flip beats a clear) and the one-entry buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_val   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_flip;
            if (!r_valid || chg_ready) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_idx <= IDXW'(w_pick.idx);
                    r_val <= w_pick.val;
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

    assign qvec      = w_q;
    assign chg_valid = r_valid;
    assign chg_idx   = r_idx;
    assign chg_val   = r_val;

endmodule

// File: tb/tb_v_hier_sub_array.sv
// tb_v_hier_sub_array: directed checks of a filtered
// (MODE 1, DEPTH 3) and a pass-through (MODE 0, DEPTH 5) array.
module tb_v_hier_sub_array;

    logic       clk;
    logic       rst_n;

    logic       a_en;
    logic [3:0] a_avec;
    logic [3:0] a_q;
    logic       a_v;
    logic       a_rdy;
    logic [1:0] a_idx;
    logic       a_val;

    logic       b_en;
    logic [3:0] b_avec;
    logic [3:0] b_q;
    logic       b_v;
    logic       b_rdy;
    logic [1:0] b_idx;
    logic       b_val;

    int total;
    int bad;

    v_hier_sub_array #(
        .CHANNELS (4),
        .DEPTH    (3),
        .MODE     (1)
    ) u_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (a_en),
        .avec      (a_avec),
        .qvec      (a_q),
        .chg_valid (a_v),
        .chg_ready (a_rdy),
        .chg_idx   (a_idx),
        .chg_val   (a_val)
    );

    v_hier_sub_array #(
        .CHANNELS (4),
        .DEPTH    (5),
        .MODE     (0)
    ) u_pass (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (b_en),
        .avec      (b_avec),
        .qvec      (b_q),
        .chg_valid (b_v),
        .chg_ready (b_rdy),
        .chg_idx   (b_idx),
        .chg_val   (b_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_evt(input string tag,
                             input logic [1:0] idx,
                             input logic val);
        chk({tag, "_v"}, 32'(a_v), 32'd1);
        chk({tag, "_idx"}, 32'(a_idx), 32'(idx));
        chk({tag, "_val"}, 32'(a_val), 32'(val));
    endtask

    task automatic chk_b_evt(input string tag,
                             input logic [1:0] idx,
                             input logic val);
        chk({tag, "_v"}, 32'(b_v), 32'd1);
        chk({tag, "_idx"}, 32'(b_idx), 32'(idx));
        chk({tag, "_val"}, 32'(b_val), 32'(val));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        a_en   = 1'b0;
        a_avec = 4'h0;
        a_rdy  = 1'b0;
        b_en   = 1'b0;
        b_avec = 4'h0;
        b_rdy  = 1'b0;

        // reset state
        tick(3);
        chk("rst_a_q", 32'(a_q), 32'h0);
        chk("rst_a_v", 32'(a_v), 32'h0);
        chk("rst_a_idx", 32'(a_idx), 32'h0);
        chk("rst_a_val", 32'(a_val), 32'h0);
        chk("rst_b_q", 32'(b_q), 32'h0);
        chk("rst_b_v", 32'(b_v), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // pass-through: all lanes rise at once
        b_en   = 1'b1;
        b_rdy  = 1'b1;
        b_avec = 4'hF;
        tick(1);
        chk("pass_q_e0", 32'(b_q), 32'h0);
        tick(1);
        chk("pass_q_e1", 32'(b_q), 32'hF);
        chk("pass_v_e1", 32'(b_v), 32'h0);
        tick(1);
        chk_b_evt("pass_ev0", 2'd0, 1'b1);
        tick(1);
        chk_b_evt("pass_ev1", 2'd1, 1'b1);
        tick(1);
        chk_b_evt("pass_ev2", 2'd2, 1'b1);
        tick(1);
        chk_b_evt("pass_ev3", 2'd3, 1'b1);
        tick(1);
        chk("pass_drained", 32'(b_v), 32'h0);

        // filtered: two-cycle pulse on lane 2 is rejected
        a_en   = 1'b1;
        a_rdy  = 1'b1;
        a_avec = 4'b0100;
        tick(2);
        a_avec = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("short_q", 32'(a_q), 32'h0);
            chk("short_v", 32'(a_v), 32'h0);
        end

        // filtered: three-cycle pulse on lane 2 flips and returns
        a_avec = 4'b0100;
        tick(3);
        chk("hold_q_e2", 32'(a_q), 32'h0);
        a_avec = 4'b0000;
        tick(1);
        chk("hold_q_e3", 32'(a_q), 32'b0100);
        chk("hold_v_e3", 32'(a_v), 32'h0);
        tick(1);
        chk_a_evt("hold_ev_rise", 2'd2, 1'b1);
        tick(1);
        chk("hold_v_e5", 32'(a_v), 32'h0);
        tick(1);
        chk("hold_q_e6", 32'(a_q), 32'h0);
        tick(1);
        chk_a_evt("hold_ev_fall", 2'd2, 1'b0);
        tick(1);
        chk("hold_v_e8", 32'(a_v), 32'h0);

        // round robin: ptr sits at 3, lanes 0 and 3 flip together
        a_avec = 4'b1001;
        tick(4);
        chk("rr_q", 32'(a_q), 32'b1001);
        chk("rr_v_pre", 32'(a_v), 32'h0);
        tick(1);
        chk_a_evt("rr_first", 2'd3, 1'b1);
        tick(1);
        chk_a_evt("rr_second", 2'd0, 1'b1);
        tick(1);
        chk("rr_drained", 32'(a_v), 32'h0);

        // backpressure: {1,1} held while lane 1 falls again
        a_rdy  = 1'b0;
        a_avec = 4'b1011;
        tick(4);
        chk("bp_q_rise", 32'(a_q), 32'b1011);
        tick(1);
        chk_a_evt("bp_first", 2'd1, 1'b1);
        a_avec = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_a_evt("bp_hold", 2'd1, 1'b1);
        end
        chk("bp_q_fall", 32'(a_q), 32'b1001);
        a_rdy = 1'b1;
        tick(1);
        chk_a_evt("bp_second", 2'd1, 1'b0);
        tick(1);
        chk("bp_drained", 32'(a_v), 32'h0);

        // enable low: inputs toggle, nothing moves
        a_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a_avec = 4'(i * 7 + 3);
            tick(1);
            chk("en_lo_q", 32'(a_q), 32'b1001);
            chk("en_lo_v", 32'(a_v), 32'h0);
        end
        a_avec = 4'b0110;
        tick(2);
        chk("en_lo_q_end", 32'(a_q), 32'b1001);

        // enable high: every lane flips after exactly three samples
        a_en = 1'b1;
        tick(2);
        chk("en_hi_q_e2", 32'(a_q), 32'b1001);
        tick(1);
        chk("en_hi_q_e3", 32'(a_q), 32'b0110);
        chk("en_hi_v_e3", 32'(a_v), 32'h0);
        tick(1);
        chk_a_evt("en_ev0", 2'd2, 1'b1);
        tick(1);
        chk_a_evt("en_ev1", 2'd3, 1'b0);
        tick(1);
        chk_a_evt("en_ev2", 2'd0, 1'b0);
        tick(1);
        chk_a_evt("en_ev3", 2'd1, 1'b1);
        tick(1);
        chk("en_drained", 32'(a_v), 32'h0);

        // reset in the middle of pending traffic
        a_rdy  = 1'b0;
        a_avec = 4'b0000;
        tick(5);
        chk_a_evt("mid_pre", 2'd2, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_q", 32'(a_q), 32'h0);
        chk("mid_rst_v", 32'(a_v), 32'h0);
        chk("mid_rst_idx", 32'(a_idx), 32'h0);
        tick(1);
        rst_n = 1'b1;
        a_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("mid_post_v", 32'(a_v), 32'h0);
            chk("mid_post_q", 32'(a_q), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v_hier_sub_array.md
# v_hier_sub_array

Parametrised successor to the four-bit hierarchy sub-block: a CHANNELS-wide array of per-lane input samplers with a programmable glitch filter, built from one generated lane cell per channel. Each stable input change updates qvec and is queued as a change event, drained one at a time through a valid/ready port in round-robin order. Sits between raw per-bit inputs and the hierarchy-walking consumer that needs both the filtered level and an ordered change log.

## Interface
- CHANNELS, 4: number of lanes; legal 1..64.
- DEPTH, 2: consecutive differing samples required before a lane's output flips; legal 1..255.
- MODE, 0: 0 = pass-through (behaves as DEPTH=1 regardless of DEPTH); 1 = filtered (DEPTH applies).
- IDXW, $clog2(CHANNELS) (minimum 1): derived, not overridden.

- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  filter enable; low freezes counters and qvec.
- avec  input  CHANNELS  raw lane inputs, asynchronous to nothing (synchronous to clk).
- qvec  output  CHANNELS  filtered lane levels.
- chg_valid  output  1  change event available.
- chg_ready  input  1  consumer accepts event.
- chg_idx  output  IDXW  lane index of the event.
- chg_val  output  1  qvec value of that lane when the event was loaded.

## Operation
- Reset (async assert, sync deassert by the integrator): sample regs, qvec, counters, pending flags, chg_valid, chg_idx, chg_val, round-robin pointer all 0.
- Per lane: s <= avec[i] every edge (also when en low). Effective depth D = (MODE==0) ? 1 : DEPTH.
- With en high: if s != q: if cnt == D-1 then q <= s, cnt <= 0, pending[i] <= 1; else cnt <= cnt+1. If s == q: cnt <= 0.
- With en low: cnt and q hold; no pending set. Pending already set still drains.
- Counter width $clog2(D+1); no wrap possible since it clears at D-1.
- Event buffer (one entry): loads when chg_valid==0 or (chg_valid && chg_ready). Selects first set pending lane searching from ptr upward, wrapping at CHANNELS-1 -> 0. On load: chg_idx <= lane, chg_val <= q[lane], pending[lane] cleared, ptr <= lane+1 (wrap), chg_valid <= 1. No pending lane: chg_valid <= 0 (only if current event transferred or buffer empty).
- Simultaneous set and clear of pending for the same lane in one cycle: set wins; event reappears later.
- Lane flipping twice before being reported: a single event, chg_val = q at load time.
- chg_idx/chg_val stable while chg_valid && !chg_ready.

## Timing
- avec stable before edge E0 -> s at E0 -> q flips at E_D (D edges after E0 if held) -> pending at E_D -> chg_valid at E_{D+1} if buffer free.
- MODE 0: avec to qvec latency 2 edges, to chg_valid 3 edges.
- Throughput: one event per cycle with chg_ready held high.
- Any input pulse shorter than D cycles (measured at s) produces no qvec change and no event.

## Structure
- Package v_hier_pkg: mode constants (V_HIER_MODE_PASS=0, V_HIER_MODE_FILT=1), clog2-based index width function, event struct {idx, val}.
- Sub-module v_hier_lane: one instance per channel in a named generate loop (genloop); contains s, cnt, q, outputs q and a one-cycle flip strobe. Pending flags, round-robin picker and event buffer live in the top.

## Test plan
- Reset mid-operation: CHANNELS=4, lanes pending, assert rst_n low between edges -> qvec=0, chg_valid=0 immediately, no event after release.
- MODE=1, DEPTH=3: lane 2 pulses high for 2 cycles -> no qvec change, no event; held 3 cycles -> qvec=4'b0100 at E3, event {idx=2,val=1} valid at E4.
- MODE=0, DEPTH=5: avec 0 -> 4'b1111 at one edge, chg_ready=1 -> qvec=4'hF at E1, events idx 0,1,2,3 on four consecutive cycles.
- Backpressure: chg_ready=0 with event {1,1} pending 10 cycles while lane 1 returns to 0 -> idx/val unchanged; on ready, {1,1} then {1,0}.
- Round robin: ptr=3 after lane 2 reported, lanes 0 and 3 pending -> order 3 then 0.
- en low: toggle avec for 20 cycles -> qvec and counters frozen, no events; en high with avec steady -> flip after D cycles.
